ks_prefix_pipe: RTL and testbench

Pipelined Kogge-Stone prefix network for the adder datapath. It consumes the per-bit generate/propagate vectors produced by the bit-level g/p cells, plus a carry-in. It computes all group carries in log2(WIDTH) registered prefix levels and emits the sum and carry-out. Throughput is one add per cycle, with valid/ready flow control and per-stage bubble collapsing.

---
 rtl/ks_prefix_pipe.sv | 85 ++++++++
 tb/tb_ks_prefix_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ks_prefix_pipe.sv
// Pipelined Kogge-Stone carry network: one input stage folds cin into bit 0,
// then log2(WIDTH) registered prefix levels, with per-stage bubble collapsing.
module ks_prefix_pipe #(
    parameter  int WIDTH  = 16,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [LEVELS:0]  v_q, v_d, ld;
    logic [LEVELS:0]  ci_q;
    logic [WIDTH-1:0] g_q  [LEVELS+1];
    logic [WIDTH-1:0] g_d  [LEVELS+1];
    logic [WIDTH-1:0] po_q [LEVELS+1];
    // The last level only consumes P, so group P stops one stage short.
    logic [WIDTH-1:0] p_q  [LEVELS];
    logic [WIDTH-1:0] p_d  [LEVELS];

    // A stage may load when empty or when its contents move on this cycle.
    always_comb begin
        ld[LEVELS] = out_ready | ~v_q[LEVELS];
        for (int k = LEVELS - 1; k >= 0; k--)
            ld[k] = ~v_q[k] | ld[k+1];
        v_d = v_q;
        if (ld[0]) v_d[0] = in_valid;
        for (int k = 1; k <= LEVELS; k++)
            if (ld[k]) v_d[k] = v_q[k-1];
    end

    always_comb begin
        g_d[0]    = g_in;
        g_d[0][0] = g_in[0] | (p_in[0] & cin);
        p_d[0]    = p_in;
        for (int k = 1; k <= LEVELS; k++) begin
            g_d[k] = g_q[k-1];
            for (int i = (1 << (k-1)); i < WIDTH; i++)
                g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-(1 << (k-1))]);
        end
        for (int k = 1; k < LEVELS; k++) begin
            p_d[k] = p_q[k-1];
            for (int i = (1 << (k-1)); i < WIDTH; i++)
                p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-(1 << (k-1))];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
    end

    // Payload registers are don't-care while their valid bit is low.
    always_ff @(posedge clk) begin
        if (ld[0]) begin
            g_q[0]  <= g_d[0];
            p_q[0]  <= p_d[0];
            po_q[0] <= p_in;
            ci_q[0] <= cin;
        end
        for (int k = 1; k <= LEVELS; k++) begin
            if (ld[k]) begin
                g_q[k]  <= g_d[k];
                po_q[k] <= po_q[k-1];
                ci_q[k] <= ci_q[k-1];
            end
        end
        for (int k = 1; k < LEVELS; k++)
            if (ld[k]) p_q[k] <= p_d[k];
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[LEVELS];
    assign sum       = po_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], ci_q[LEVELS]};
    assign cout      = g_q[LEVELS][WIDTH-1];

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// Directed bench for ks_prefix_pipe (WIDTH=16) with an in-order scoreboard.
module tb_ks_prefix_pipe;

    localparam int W  = 16;
    localparam int LV = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0] g_in, p_in, sum;

    int           n_chk  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    logic [W:0]   exp_in;
    logic [W:0]   sb_e;
    logic [W:0]   sbq[$];

    ks_prefix_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .g_in(g_in), .p_in(p_in), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (rst) sbq.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'd0);
                else begin
                    sb_e = sbq.pop_front();
                    chk("sb_result", {15'b0, cout, sum}, {15'b0, sb_e});
                end
            end
            if (in_valid && in_ready) sbq.push_back(exp_in);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        g_in     = a & b;
        p_in     = a ^ b;
        cin      = c;
        exp_in   = {1'b0, a} + {1'b0, b} + {16'b0, c};
        in_valid = 1'b1;
    endtask

    // Call just after a rising edge; returns just after the capture edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bit ok = 0;
        drive(a, b, c);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", {31'b0, in_ready}, 32'd1);
        step();
    endtask

    // Latency counted in rising edges, the capture edge being edge 1.
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [W-1:0] bp_a [6] = '{16'h00FF, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h1111, 16'hAAAA};
    logic [W-1:0] bp_b [6] = '{16'h0001, 16'hFFFF, 16'h8000, 16'hF0F0, 16'h2222, 16'h5555};
    logic         bp_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int lat, t0, acc, idx;
        bit took;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        g_in = '0; p_in = '0; cin = 1'b0; exp_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        step();

        // Full carry ripple from bit 0 to cout
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0); in_valid = 1'b0;
        wait_out(lat);
        chk("ripple_latency", lat, LV + 1);
        chk("ripple_sum",  {16'b0, sum},  32'h0000);
        chk("ripple_cout", {31'b0, cout}, 32'd1);
        step();

        send(16'h7FFF, 16'h0000, 1'b1); in_valid = 1'b0;
        wait_out(lat);
        chk("cin_latency", lat, LV + 1);
        chk("cin_sum",  {16'b0, sum},  32'h8000);
        chk("cin_cout", {31'b0, cout}, 32'd0);
        step();

        send(16'h0000, 16'h0000, 1'b1); in_valid = 1'b0;
        wait_out(lat);
        chk("cin0_sum",  {16'b0, sum},  32'h0001);
        chk("cin0_cout", {31'b0, cout}, 32'd0);
        step();

        // Back-to-back stream at full rate
        t0 = cyc;
        for (int i = 0; i < 1000; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
        in_valid = 1'b0;
        chk("b2b_cycles", cyc - t0, 1000);
        repeat (10) step();
        chk("b2b_drained", sbq.size(), 0);

        // Backpressure: capacity is LEVELS+1 entries
        out_ready = 1'b0;
        acc = 0; idx = 0;
        drive(bp_a[0], bp_b[0], bp_c[0]);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            step();
            if (took && idx < 5) begin idx++; drive(bp_a[idx], bp_b[idx], bp_c[idx]); end
        end
        @(negedge clk);
        chk("bp_accepts",  acc, 5);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold0", {15'b0, cout, sum}, 32'h00100);
        in_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("bp_hold1",  {15'b0, cout, sum}, 32'h00100);
        chk("bp_valid",  {31'b0, out_valid}, 32'd1);
        step();
        out_ready = 1'b1;
        repeat (10) step();
        chk("bp_drained", sbq.size(), 0);

        // Random bubbles on both sides
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            step();
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid || took) begin
                if ($urandom_range(0, 1) == 1) drive(16'($urandom), 16'($urandom), 1'($urandom));
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) step();
        chk("rnd_drained", sbq.size(), 0);

        // Reset with three entries in flight
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0);
        send(16'h0303, 16'h0404, 1'b1);
        send(16'h0505, 16'h0606, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        step();
        out_ready = 1'b1;
        send(16'h1234, 16'h4321, 1'b0); in_valid = 1'b0;
        wait_out(lat);
        chk("rst_latency", lat, LV + 1);
        chk("rst_sum",  {16'b0, sum},  32'h5555);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        repeat (5) step();
        chk("final_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
